uart_rx_slave: RTL and testbench
================================

Name: uart_rx_slave

Overview:
- Bus-mapped UART receiver: the receive end of the SoC serial link, complementing the existing transmit-only UART slave.
- Sits on a bus slave port with the same HSEL/HADDR/HWRITE/HWDATA/HRDATA signalling as the other slaves.
- Deserialises 8N1 frames from the RX pin into a small FIFO and raises a level interrupt for the core's interrupt input.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 434, reset value of BAUD_DIV in clock cycles per bit (50 MHz / 115200).

Ports:
- clock  input  1  system clock.
- nRst  input  1  asynchronous, active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  32  byte address; only HADDR[3:2] is decoded.
- HWRITE  input  1  1 = write, 0 = read.
- HWDATA  input  32  write data.
- HRDATA  output  32  read data.
- RX  input  1  serial input, idles high, asynchronous to clock.
- interrupt  output  1  level interrupt request.

Behaviour:
- Register map (offset from HADDR[3:2]):
  - 0x0 RXDATA (read-only): [7:0] is the FIFO head; reads 0 when the FIFO is empty.
  - 0x4 STATUS: bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), bits[15:8] fill count. Writing 1 to bit2 or bit3 clears that bit.
  - 0x8 BAUD_DIV: [15:0], read/write; written values below 4 are stored as 4.
  - 0xC CTRL: bit0 rx_en, bit1 irq_en.
- HRDATA is combinational from HADDR[3:2] and reads 0 when HSEL=0. Unused bits read 0.
- Writes take effect on the clock edge where HSEL=1 and HWRITE=1.
- A read of RXDATA (HSEL=1, HWRITE=0, offset 0x0) pops the FIFO on that edge. Popping an empty FIFO has no effect.
- Reset values:
  - HRDATA=0 and interrupt=0.
  - FIFO empty; STATUS sticky bits 0.
  - BAUD_DIV=DEFAULT_DIV.
  - CTRL=0.
  - FSM in IDLE.
- RX passes through a 2-flop synchroniser, giving 2 cycles of input latency.
- FSM states:
  - IDLE: when rx_en=1 and the synchronised RX is 0 (falling edge detected), load the counter with BAUD_DIV>>1 and go to START.
  - START: when the counter expires, sample RX. If RX=1 it was a glitch, so return to IDLE. Otherwise reload the counter with BAUD_DIV and go to DATA.
  - DATA: sample one bit every BAUD_DIV cycles, LSB first. After the 8th bit go to STOP.
  - STOP: sample RX after BAUD_DIV cycles.
    - RX=1: push the byte and go to IDLE.
    - RX=0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: remain until RX=1, then go to IDLE (this absorbs break conditions).
- The counter decrements each cycle and "expires" at 1; each reload uses the current BAUD_DIV.
- Push/pop interaction:
  - A push while the FIFO is full with no simultaneous pop sets overrun and drops the new byte; the FIFO contents are preserved.
  - A simultaneous push and pop on a full FIFO succeeds, and the count stays at FIFO_DEPTH.
  - A simultaneous push and pop on an empty FIFO pushes the byte and leaves the pop with no effect; the count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- rx_en cleared mid-frame: the FSM returns to IDLE on the next edge, the partial byte is discarded, and the FIFO is untouched.
- Writing BAUD_DIV mid-frame affects only subsequent counter reloads.
- interrupt = irq_en & (not_empty | overrun | frame_err), registered, so it lags by 1 cycle.
- nRst asserted mid-frame returns every register to its reset value immediately.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP; it samples one even-parity bit.
  - On mismatch, STATUS bit4 parity_err (sticky, W1C) is set and the byte is discarded.
  - parity_err is also ORed into the interrupt source.
- Undefined: 8N1 only, with no PARITY state. STATUS bit4 reads 0.

Decomposition:
- Package uart_pkg:
  - Register offset constants: RXDATA=2'd0, STATUS=2'd1, BAUD_DIV=2'd2, CTRL=2'd3.
  - STATUS bit-index constants.
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - DEFAULT_DIV constant.
- Sub-module uart_rx_fifo (parameter DEPTH): synchronous FIFO with push, pop, din, dout, full, empty and count.

Test Plan:
- BAUD_DIV=8, rx_en=1; send 0xA5 as 8N1 → STATUS=0x0101 within 80 cycles of the start edge; RXDATA read returns 0xA5; STATUS then reads 0x0000.
- irq_en=1, FIFO_DEPTH=4; send 0x01..0x05 without reading → after the 5th byte STATUS bit2=1 and bit1=1; reads return 0x01..0x04, then 0; write STATUS=0x4 → bit2=0.
- Send a frame with a 0 stop bit and data 0x3C → frame_err=1 and the FIFO stays empty; interrupt=1 one cycle after the flag sets; the FSM stays in WAIT_HIGH until RX returns high.
- BAUD_DIV=16; 3-cycle low pulse on RX → no byte received, no error flag set, FSM back in IDLE.
- Assert nRst mid-byte (bit 4 of 0x55), release it, then send 0x5A with BAUD_DIV rewritten to 8 → only 0x5A is received; BAUD_DIV read back as 434 before the rewrite.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 → parity_err=1 and no byte received; send 0x07 with parity bit 1 → 0x07 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and receiver FSM states for uart_rx_slave.
package uart_pkg;

   localparam logic [1:0] RXDATA   = 2'd0;
   localparam logic [1:0] STATUS   = 2'd1;
   localparam logic [1:0] BAUD_DIV = 2'd2;
   localparam logic [1:0] CTRL     = 2'd3;

   localparam int unsigned STAT_NOT_EMPTY  = 0;
   localparam int unsigned STAT_FULL       = 1;
   localparam int unsigned STAT_OVERRUN    = 2;
   localparam int unsigned STAT_FRAME_ERR  = 3;
   localparam int unsigned STAT_PARITY_ERR = 4;

   localparam logic [15:0] DEFAULT_DIV = 16'd434;
   localparam logic [15:0] MIN_DIV     = 16'd4;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;

endpackage

// File: rtl/uart_rx_slave_if.sv
// Bus slave port bundle shared by the SoC peripheral slaves.
interface uart_rx_slave_if;

   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;

   modport master (output HSEL, output HADDR, output HWRITE, output HWDATA, input HRDATA);
   modport slave  (input HSEL, input HADDR, input HWRITE, input HWDATA, output HRDATA);

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for the UART receiver; a push into a full FIFO only lands if a pop frees a slot.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   nRst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             din,
   output logic [7:0]             dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_slave.sv
// Bus-mapped 8N1 UART receiver with a byte FIFO and level interrupt.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_slave #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
   input  logic            clock,
   input  logic            nRst,
   uart_rx_slave_if.slave  bus,
   input  logic            RX,
   output logic            interrupt
);

   import uart_pkg::*;

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   rx_state_t   state_q, state_d;
   logic        rx_meta_q, rx_sync_q;
   logic [15:0] cnt_q, cnt_d, baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_en_q, rx_en_d, irq_en_q, irq_en_d;
   logic        overrun_q, overrun_d, frame_err_q, frame_err_d, irq_q, irq_d;
   logic        push, set_frame_err, expire, parity_err;
   logic        wr_en, rd_pop, fifo_full, fifo_empty;
   logic [1:0]  addr;
   logic [7:0]  fifo_dout;
   logic [CW-1:0] fifo_count;
   logic        unused_bus_bits;

`ifdef UART_RX_PARITY_EN
   logic        parity_err_q, parity_err_d, par_bad_q, par_bad_d, set_parity_err;
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign addr            = bus.HADDR[3:2];
   assign wr_en           = bus.HSEL & bus.HWRITE;
   assign rd_pop          = bus.HSEL & ~bus.HWRITE & (addr == RXDATA);
   assign expire          = (cnt_q == 16'd1);
   assign interrupt       = irq_q;
   assign unused_bus_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:16]};

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .nRst  (nRst),
      .push  (push),
      .pop   (rd_pop),
      .din   (shift_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      push          = 1'b0;
      set_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d      = par_bad_q;
      set_parity_err = 1'b0;
`endif
      unique case (state_q)
         IDLE: if (rx_en_q && !rx_sync_q) begin
            cnt_d   = baud_q >> 1;
            state_d = START;
         end
         START: if (expire) begin
            if (rx_sync_q) begin
               state_d = IDLE;
            end else begin
               cnt_d     = baud_q;
               bit_idx_d = '0;
               state_d   = DATA;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end
         end
         DATA: if (expire) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            cnt_d     = baud_q;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (expire) begin
            cnt_d   = baud_q;
            state_d = STOP;
            if (rx_sync_q != ^shift_q) begin
               set_parity_err = 1'b1;
               par_bad_d      = 1'b1;
            end
         end
`endif
         STOP: if (expire) begin
            if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
               push = ~par_bad_q;
`else
               push = 1'b1;
`endif
               state_d = IDLE;
            end else begin
               set_frame_err = 1'b1;
               state_d       = WAIT_HIGH;
            end
         end
         WAIT_HIGH: if (rx_sync_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Disabling the receiver abandons any frame in flight without side effects.
      if (!rx_en_q) begin
         state_d       = IDLE;
         push          = 1'b0;
         set_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
         set_parity_err = 1'b0;
`endif
      end
   end

   always_comb begin
      baud_d      = baud_q;
      rx_en_d     = rx_en_q;
      irq_en_d    = irq_en_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (wr_en) begin
         case (addr)
            STATUS: begin
               if (bus.HWDATA[STAT_OVERRUN])   overrun_d   = 1'b0;
               if (bus.HWDATA[STAT_FRAME_ERR]) frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
               if (bus.HWDATA[STAT_PARITY_ERR]) parity_err_d = 1'b0;
`endif
            end
            BAUD_DIV: baud_d = (bus.HWDATA[15:0] < MIN_DIV) ? MIN_DIV : bus.HWDATA[15:0];
            CTRL: begin
               rx_en_d  = bus.HWDATA[0];
               irq_en_d = bus.HWDATA[1];
            end
            default: ;
         endcase
      end
      // Hardware set wins over a same-cycle software clear.
      if (push && fifo_full && !rd_pop) overrun_d = 1'b1;
      if (set_frame_err) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (set_parity_err) parity_err_d = 1'b1;
`endif
      irq_d = irq_en_q & (~fifo_empty | overrun_q | frame_err_q | parity_err);
   end

   always_comb begin
      bus.HRDATA = '0;
      if (bus.HSEL) begin
         case (addr)
            RXDATA:   bus.HRDATA[7:0] = fifo_empty ? 8'h00 : fifo_dout;
            STATUS: begin
               bus.HRDATA[STAT_NOT_EMPTY]  = ~fifo_empty;
               bus.HRDATA[STAT_FULL]       = fifo_full;
               bus.HRDATA[STAT_OVERRUN]    = overrun_q;
               bus.HRDATA[STAT_FRAME_ERR]  = frame_err_q;
               bus.HRDATA[STAT_PARITY_ERR] = parity_err;
               bus.HRDATA[15:8]            = 8'(fifo_count);
            end
            BAUD_DIV: bus.HRDATA[15:0] = baud_q;
            default:  bus.HRDATA[1:0]  = {irq_en_q, rx_en_q};
         endcase
      end
   end

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         baud_q      <= DEFAULT_DIV;
         rx_en_q     <= 1'b0;
         irq_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         irq_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
         par_bad_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q   <= RX;
         rx_sync_q   <= rx_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         baud_q      <= baud_d;
         rx_en_q     <= rx_en_d;
         irq_en_q    <= irq_en_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         irq_q       <= irq_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
         par_bad_q    <= par_bad_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_slave.sv
// Randomised scoreboard bench for uart_rx_slave; honours UART_RX_PARITY_EN like the RTL.
module tb_uart_rx_slave;

   import uart_pkg::*;

   localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clock = 1'b0;
   logic nRst;
   logic RX;
   logic interrupt;
   int   n_tests = 0;
   int   n_fail  = 0;

   uart_rx_slave_if bus ();

   uart_rx_slave #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
      .clock     (clock),
      .nRst      (nRst),
      .bus       (bus),
      .RX        (RX),
      .interrupt (interrupt)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: expected read data queued at issue time, checked by the monitor.
   logic [31:0] exp_q[$];
   string       name_q[$];

   // Reference model of the receiver as seen from the bus.
   logic [7:0] m_fifo[$];
   bit         m_ovr, m_ferr, m_perr, m_irq_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (nRst && bus.HSEL && !bus.HWRITE) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: got 0x%08h, expected no read", bus.HRDATA);
         end else begin
            check(name_q.pop_front(), bus.HRDATA, exp_q.pop_front());
         end
      end
   end

   function automatic logic [31:0] m_status();
      return {16'h0, 8'(m_fifo.size()), 3'b0, m_perr, m_ferr, m_ovr,
              m_fifo.size() == DEPTH, m_fifo.size() != 0};
   endfunction

   function automatic logic m_irq();
      return m_irq_en & ((m_fifo.size() != 0) | m_ovr | m_ferr | m_perr);
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = {28'h0, a, 2'b00}; bus.HWDATA = d;
      wait_cyc(1);
      bus.HSEL = 1'b0; bus.HWRITE = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      exp_q.push_back(exp);
      name_q.push_back(name);
      bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = {28'h0, a, 2'b00};
      wait_cyc(1);
      bus.HSEL = 1'b0;
   endtask

   task automatic read_data();
      logic [7:0] e;
      e = (m_fifo.size() != 0) ? m_fifo.pop_front() : 8'h00;
      bus_rd(RXDATA, {24'h0, e}, "rxdata");
   endtask

   task automatic read_status(input string name);
      bus_rd(STATUS, m_status(), name);
   endtask

   task automatic w1c(input logic [31:0] mask);
      bus_wr(STATUS, mask);
      if (mask[2]) m_ovr = 1'b0;
      if (mask[3]) m_ferr = 1'b0;
      if (mask[4]) m_perr = 1'b0;
   endtask

   task automatic wr_ctrl(input bit rx_en, input bit irq_en);
      bus_wr(CTRL, {30'h0, irq_en, rx_en});
      m_irq_en = irq_en;
   endtask

   task automatic check_irq(input string name);
      check(name, {31'h0, interrupt}, {31'h0, m_irq()});
   endtask

   // One frame at div cycles per bit; the model decides the outcome from the frame contents.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                             input int div, input bit leave_low);
      RX = 1'b0;
      wait_cyc(div);
      for (int i = 0; i < 8; i++) begin
         RX = d[i];
         wait_cyc(div);
      end
`ifdef UART_RX_PARITY_EN
      RX = (^d) ^ ~par_ok;
      wait_cyc(div);
`endif
      RX = stop_ok;
      wait_cyc(div);
      if (!leave_low) begin
         RX = 1'b1;
         wait_cyc(4);
      end
      if (PAR && !par_ok) m_perr = 1'b1;
      if (!stop_ok) m_ferr = 1'b1;
      if (stop_ok && (par_ok || !PAR)) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
         else m_ovr = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_irq_en = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int         div;
      bit         stop_ok, par_ok;

      bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
      RX = 1'b1;
      nRst = 1'b0;
      model_reset();
      wait_cyc(3);
      nRst = 1'b1;
      wait_cyc(2);

      // Reset state
      check("reset_irq", {31'h0, interrupt}, 32'h0);
      check("hrdata_unselected", bus.HRDATA, 32'h0);
      read_status("reset_status");
      bus_rd(BAUD_DIV, 32'd434, "reset_baud");
      bus_rd(CTRL, 32'h0, "reset_ctrl");
      read_data();

      // Single 0xA5 frame
      bus_wr(BAUD_DIV, 32'd8);
      wr_ctrl(1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, 8, 1'b0);
      bus_rd(STATUS, 32'h0000_0101, "a5_status");
      m_fifo.delete();
      bus_rd(RXDATA, 32'h0000_00A5, "a5_data");
      bus_rd(STATUS, 32'h0, "a5_status_empty");

      // Overrun: five bytes into a four-deep FIFO
      wr_ctrl(1'b1, 1'b1);
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 8, 1'b0);
      bus_rd(STATUS, 32'h0000_0407, "ovr_status");
      check_irq("ovr_irq");
      for (int i = 0; i < 5; i++) read_data();
      w1c(32'h4);
      read_status("ovr_cleared");
      wait_cyc(1);
      check_irq("ovr_irq_clear");

      // Frame error with RX held low (break) afterwards
      send_frame(8'h3C, 1'b0, 1'b1, 8, 1'b1);
      check_irq("ferr_irq");
      bus_rd(STATUS, 32'h0000_0008, "ferr_status");
      w1c(32'h8);
      wait_cyc(12 * 8);
      read_status("ferr_wait_high");
      RX = 1'b1;
      wait_cyc(4);
      send_frame(8'hC3, 1'b1, 1'b1, 8, 1'b0);
      read_status("after_break");
      read_data();

      // Short glitch on RX
      bus_wr(BAUD_DIV, 32'd16);
      RX = 1'b0;
      wait_cyc(3);
      RX = 1'b1;
      wait_cyc(40);
      read_status("glitch_status");
      send_frame(8'h96, 1'b1, 1'b1, 16, 1'b0);
      read_data();

      // Receiver disabled mid-frame keeps the FIFO intact
      send_frame(8'h11, 1'b1, 1'b1, 16, 1'b0);
      RX = 1'b0;
      wait_cyc(16 * 4);
      wr_ctrl(1'b0, 1'b1);
      RX = 1'b1;
      wait_cyc(16 * 8);
      read_status("rxen_off_status");
      wr_ctrl(1'b1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b1, 16, 1'b0);
      read_status("rxen_on_status");
      read_data();
      read_data();

      // Baud divisor floor
      div = $urandom_range(0, 3);
      bus_wr(BAUD_DIV, 32'(div));
      bus_rd(BAUD_DIV, 32'd4, "baud_floor");

      // Reset in the middle of 0x55
      bus_wr(BAUD_DIV, 32'd8);
      d = 8'h55;
      RX = 1'b0;
      wait_cyc(8);
      for (int i = 0; i < 4; i++) begin
         RX = d[i];
         wait_cyc(8);
      end
      RX = d[4];
      wait_cyc(4);
      nRst = 1'b0;
      RX = 1'b1;
      wait_cyc(3);
      nRst = 1'b1;
      model_reset();
      wait_cyc(1);
      check_irq("rst_irq");
      bus_rd(BAUD_DIV, 32'd434, "rst_baud");
      bus_rd(CTRL, 32'h0, "rst_ctrl");
      read_status("rst_status");
      bus_wr(BAUD_DIV, 32'd8);
      wr_ctrl(1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b1, 8, 1'b0);
      bus_rd(STATUS, 32'h0000_0101, "5a_status");
      read_data();
      read_data();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 8, 1'b0);
      bus_rd(STATUS, 32'h0000_0010, "par_bad_status");
      w1c(32'h10);
      send_frame(8'h07, 1'b1, 1'b1, 8, 1'b0);
      bus_rd(STATUS, 32'h0000_0101, "par_ok_status");
      read_data();
`endif

      // Randomised frames, divisors, errors and read-back
      wr_ctrl(1'b1, 1'b1);
      for (int it = 0; it < 24; it++) begin
         div = $urandom_range(8, 20);
         bus_wr(BAUD_DIV, 32'(div));
         d       = 8'($urandom);
         stop_ok = ($urandom_range(0, 5) != 0);
         par_ok  = ($urandom_range(0, 4) != 0);
         send_frame(d, stop_ok, par_ok, div, 1'b0);
         check_irq("rand_irq");
         if ($urandom_range(0, 2) == 0) read_status("rand_status");
         if ($urandom_range(0, 1) == 0) read_data();
         if ($urandom_range(0, 3) == 0) w1c(32'h1C);
      end

      while (m_fifo.size() != 0) read_data();
      read_data();
      w1c(32'h1C);
      read_status("final_status");
      wait_cyc(2);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
